// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a buffered multi-cycle result unit.
// Optional WB_BYPASS_EN: results arriving at an idle, empty arbiter write straight through.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        mc_valid,
  input  logic [4:0]  mc_waddr,
  input  logic [31:0] mc_wdata,
  output logic        mc_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_req,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic        hazard1,
  output logic        hazard2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt;

  logic head_vld, head_live, pipe_req;
  logic pop, push, pipe_gnt, bypass;
  logic hit1, hit2;

  assign head_vld  = (count != '0);
  assign head_live = head_vld && live_q[rd_ptr];
  assign pipe_req  = pipe_we && (pipe_waddr != 5'd0);
  assign mc_ready  = !rst && (count < CW'(DEPTH));

  // Fixed-priority grant; a head that has waited MAX_WAIT cycles pre-empts the pipeline.
  always_comb begin
    pop       = 1'b0;
    pipe_gnt  = 1'b0;
    bypass    = 1'b0;
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'd0;
    stall_req = 1'b0;
    if (!rst) begin
      if (head_vld && !head_live) begin
        pop = 1'b1;
        if (pipe_req) begin
          pipe_gnt = 1'b1;
          we       = 1'b1;
          waddr    = pipe_waddr;
          wdata    = pipe_wdata;
        end
      end else if (head_live && (wait_cnt == WW'(MAX_WAIT))) begin
        pop       = 1'b1;
        we        = 1'b1;
        waddr     = addr_q[rd_ptr];
        wdata     = data_q[rd_ptr];
        stall_req = pipe_req;
      end else if (pipe_req) begin
        pipe_gnt = 1'b1;
        we       = 1'b1;
        waddr    = pipe_waddr;
        wdata    = pipe_wdata;
      end else if (head_live) begin
        pop   = 1'b1;
        we    = 1'b1;
        waddr = addr_q[rd_ptr];
        wdata = data_q[rd_ptr];
      end
`ifdef WB_BYPASS_EN
      else if (!head_vld && mc_valid && (mc_waddr != 5'd0)) begin
        bypass = 1'b1;
        we     = 1'b1;
        waddr  = mc_waddr;
        wdata  = mc_wdata;
      end
`endif
    end
  end

  assign push = mc_valid && mc_ready && (mc_waddr != 5'd0) && !bypass;

  // A granted pipeline write supersedes any older buffered write to the same register.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_gnt && live_q[i] && (addr_q[i] == pipe_waddr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr] = 1'b0;
    if (push) live_d[wr_ptr] = 1'b1;
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == raddr1)) hit1 = 1'b1;
      if (live_q[i] && (addr_q[i] == raddr2)) hit2 = 1'b1;
    end
    hazard1 = !rst && re1 && (raddr1 != 5'd0) && hit1;
    hazard2 = !rst && re2 && (raddr2 != 5'd0) && hit2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      live_q <= live_d;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (pop)
        wait_cnt <= '0;
      else if (head_live && (wait_cnt != WW'(MAX_WAIT)))
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mc_waddr;
      data_q[wr_ptr] <= mc_wdata;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline writeback (MEM/WB) and a multi-cycle result unit (divider/long-latency ops).
- Multi-cycle results are buffered in a small FIFO. Starvation is bounded by a wait counter that forces a buffered write and stalls the pipeline.
- Flags read-after-write hazards for ID-stage reads whose source registers are still waiting in the buffer.

Parameters:
- DEPTH, 2, number of buffered multi-cycle results (power of two, >=2).
- MAX_WAIT, 4, cycles a live FIFO head may lose arbitration before it is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pipe_we  in  1  pipeline writeback enable
- pipe_waddr  in  5  pipeline writeback register address
- pipe_wdata  in  32  pipeline writeback data
- mc_valid  in  1  multi-cycle result valid
- mc_waddr  in  5  multi-cycle destination register
- mc_wdata  in  32  multi-cycle result data
- mc_ready  out  1  arbiter can accept a multi-cycle result this cycle
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- stall_req  out  1  pipeline writeback lost the port; freeze MEM/WB and earlier stages
- re1  in  1  ID read-port-1 enable
- raddr1  in  5  ID read address 1
- re2  in  1  ID read-port-2 enable
- raddr2  in  5  ID read address 2
- hazard1  out  1  raddr1 pending in buffer
- hazard2  out  1  raddr2 pending in buffer

Behaviour:
- Reset: FIFO emptied, all entry valid/kill bits cleared, wait_cnt=0. While rst=1, every output is 0 (including mc_ready).
- FIFO entry fields: {live, addr[4:0], data[31:0]}. count ranges 0..DEPTH, with wrapping read/write pointers.
- mc_ready = !rst && (count < DEPTH).
- Push: when mc_valid && mc_ready. If mc_waddr==0 the result is accepted and discarded (no push).
- Pipeline request: pipe_req = pipe_we && pipe_waddr!=0.
- Grant, evaluated combinationally each cycle in this order:
  1. Head present and not live (killed): pop with no write. The port goes to the pipeline if pipe_req.
  2. Head live and wait_cnt==MAX_WAIT: head wins. we=1, waddr/wdata=head, pop. stall_req=pipe_req.
  3. pipe_req: pipeline wins. we=1, waddr/wdata=pipe.
  4. Head live: head wins, pop.
  5. Otherwise we=0, waddr=0, wdata=0.
- wait_cnt: resets to 0 on any pop. Increments, saturating at MAX_WAIT, on cycles where a live head is present and not granted.
- Kill rule: a granted pipeline write whose address matches any live buffered entry clears that entry's live bit in the same cycle. The younger pipeline write supersedes the buffered one; the killed entry never writes.
- Simultaneous push and pop: count unchanged. Push on a full FIFO cannot occur (mc_ready=0).
- Push/kill same cycle, same address: the incoming entry is NOT killed.
- Latency: multi-cycle result reaches the port no earlier than 1 cycle after acceptance.
- Hazards: hazardN = reN && raddrN!=0 && raddrN matches any live buffered entry. Purely combinational; the incoming mc entry is not included.
- The pipeline holds pipe_we/waddr/wdata stable across a cycle where stall_req=1.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_req=0, mc_valid=1 and mc_waddr!=0, the result is written through in the same cycle (we=1, waddr=mc_waddr, wdata=mc_wdata) with no push. Push occurs only if the bypass is not taken.
- Undefined: every multi-cycle result goes through the FIFO, minimum 1-cycle latency.

Test Plan:
- Reset: hold rst=1 with pipe_we=1, mc_valid=1 -> we=0, waddr=0, wdata=0, mc_ready=0, stall_req=0, hazard1/2=0. First cycle after release -> mc_ready=1, count=0.
- Simple path (no bypass): mc_valid addr 5, data 0x00001234 in cycle N with pipeline idle -> cycle N+1: we=1, waddr=5, wdata=0x00001234; mc_ready stays 1.
- Full/backpressure: pipe_we=1 to addr 3 every cycle; push addr 7 then addr 8 -> mc_ready=0 from the cycle after the second push, until the first forced pop.
- Starvation: addr 7 data 0xA5 buffered, pipe_we=1 to addr 3 continuously -> head loses 4 cycles. On the 5th cycle: we=1, waddr=7, wdata=0xA5, stall_req=1. Next cycle: waddr=3, stall_req=0.
- Kill: addr 9 data 0x11 buffered, pipeline writes addr 9 data 0xAA the same cycle -> output waddr=9, wdata=0xAA; hazard for raddr1=9 drops to 0 the next cycle; no later write to addr 9.
- Hazard: addr 6 buffered and held, re1=1 raddr1=6, re2=1 raddr2=0 -> hazard1=1, hazard2=0. Same with re1=0 -> hazard1=0.
